// File: rtl/bfm_apb_master_arbiter_pkg.sv
// Shared definitions for the BFM APB master arbiter: FSM encoding and sizing constants.
package bfm_apb_arb_pkg;
  localparam int unsigned MAX_MASTERS = 4;
  localparam int unsigned ARB_IDX_W   = 2;
  localparam int unsigned TMO_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_e;
endpackage

// File: rtl/bfm_apb_master_arbiter_if.sv
// Requester-side and bridge-side APB signals of the arbiter, bundled with arbiter/environment views.
interface bfm_apb_master_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]    PSEL_RQ;
  logic [NUM_MASTERS-1:0]    PENABLE_RQ;
  logic [NUM_MASTERS-1:0]    PWRITE_RQ;
  logic [32*NUM_MASTERS-1:0] PADDR_RQ;
  logic [32*NUM_MASTERS-1:0] PWDATA_RQ;
  logic [31:0]               PRDATA_RQ;
  logic [NUM_MASTERS-1:0]    PREADY_RQ;
  logic [NUM_MASTERS-1:0]    PSLVERR_RQ;
  logic [NUM_MASTERS-1:0]    GNT_RQ;
  logic [31:0]               PADDR_PM;
  logic                      PWRITE_PM;
  logic                      PENABLE_PM;
  logic [31:0]               PWDATA_PM;
  logic [31:0]               PRDATA_PM;
  logic                      PREADY_PM;
  logic                      PSLVERR_PM;
  logic                      TIMEOUT;

  // Arbiter view: drives PM bus and requester responses.
  modport master (
    input  PSEL_RQ, PENABLE_RQ, PWRITE_RQ, PADDR_RQ, PWDATA_RQ,
    input  PRDATA_PM, PREADY_PM, PSLVERR_PM,
    output PRDATA_RQ, PREADY_RQ, PSLVERR_RQ, GNT_RQ,
    output PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM, TIMEOUT
  );

  // Environment view: requesters plus bridge.
  modport slave (
    output PSEL_RQ, PENABLE_RQ, PWRITE_RQ, PADDR_RQ, PWDATA_RQ,
    output PRDATA_PM, PREADY_PM, PSLVERR_PM,
    input  PRDATA_RQ, PREADY_RQ, PSLVERR_RQ, GNT_RQ,
    input  PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM, TIMEOUT
  );
endinterface

// File: rtl/bfm_apb_master_arbiter_rr.sv
// Combinational round-robin select: first request at or above the pointer, wrapping modulo NUM_MASTERS.
module bfm_rr_arbiter
  import bfm_apb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ARB_IDX_W-1:0]   ptr,
  output logic [ARB_IDX_W-1:0]   win_idx,
  output logic                   any_req
);
  int unsigned            cand;
  logic [NUM_MASTERS-1:0] sh;
  logic                   found;

  always_comb begin
    win_idx = '0;
    any_req = |req;
    found   = 1'b0;
    cand    = 0;
    sh      = '0;
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      cand = (ptr + off) % NUM_MASTERS;
      sh   = req >> cand;
      if (!found && sh[0]) begin
        found   = 1'b1;
        win_idx = ARB_IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/bfm_apb_master_arbiter.sv
// Round-robin sharing of the bridge PM port among APB requesters; one transfer in flight, sticky stall flag.
module bfm_apb_master_arbiter
  import bfm_apb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                       PCLK_PM,
  input logic                       PRESETN_PM,
  bfm_apb_master_arbiter_if.master  bus
);
  localparam logic [TMO_CNT_W:0]   TMO_LIMIT = (TMO_CNT_W + 1)'(TIMEOUT_CYCLES);
  localparam logic [ARB_IDX_W-1:0] LAST_IDX  = ARB_IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [ARB_IDX_W-1:0]   ptr_q, gnt_q, win_idx, ptr_nxt;
  logic                   any_req;
  logic [NUM_MASTERS-1:0] gnt_oh;
  logic [31:0]            paddr_q, pwdata_q, prdata_q, win_addr, win_wdata;
  logic                   pwrite_q, win_write, err_q, timeout_q;
  logic [TMO_CNT_W-1:0]   tmo_cnt_q;
  logic [TMO_CNT_W:0]     tmo_inc;
  logic                   psel_g, penable_g, rq_ready;

  bfm_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
    .req     (bus.PSEL_RQ),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    gnt_oh    = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q == ARB_IDX_W'(i)) gnt_oh[i] = 1'b1;
      if (win_idx == ARB_IDX_W'(i)) begin
        win_addr  = bus.PADDR_RQ[32*i +: 32];
        win_wdata = bus.PWDATA_RQ[32*i +: 32];
        win_write = bus.PWRITE_RQ[i];
      end
    end
  end

  assign psel_g    = |(bus.PSEL_RQ & gnt_oh);
  assign penable_g = |(bus.PENABLE_RQ & gnt_oh);
  assign rq_ready  = (state_q == RESP) && psel_g && penable_g;
  assign ptr_nxt   = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
  assign tmo_inc   = {1'b0, tmo_cnt_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (bus.PREADY_PM) state_d = RESP;
      // A withdrawn requester releases the slot at once; its response is dropped.
      RESP:    if (rq_ready || !psel_g) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      prdata_q  <= '0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (any_req) begin
          gnt_q     <= win_idx;
          paddr_q   <= win_addr;
          pwdata_q  <= win_wdata;
          pwrite_q  <= win_write;
          tmo_cnt_q <= '0;
        end
        ACCESS: begin
          if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_inc[TMO_CNT_W-1:0];
          if (tmo_inc >= TMO_LIMIT) timeout_q <= 1'b1;
          if (bus.PREADY_PM) begin
            prdata_q <= bus.PRDATA_PM;
            err_q    <= bus.PSLVERR_PM;
          end
        end
        RESP: if (state_d == IDLE) ptr_q <= ptr_nxt;
        default: ;
      endcase
    end
  end

  assign bus.PADDR_PM   = paddr_q;
  assign bus.PWDATA_PM  = pwdata_q;
  assign bus.PWRITE_PM  = pwrite_q;
  assign bus.PENABLE_PM = (state_q == ACCESS);
  assign bus.PRDATA_RQ  = prdata_q;
  assign bus.TIMEOUT    = timeout_q;
  assign bus.GNT_RQ     = (state_q == IDLE) ? '0 : gnt_oh;
  assign bus.PREADY_RQ  = rq_ready ? gnt_oh : '0;
  assign bus.PSLVERR_RQ = (rq_ready && err_q) ? gnt_oh : '0;
endmodule

// File: tb/tb_bfm_apb_master_arbiter.sv
// Directed bench for bfm_apb_master_arbiter: vector table plus contention, timeout, withdraw and reset sequences.
module tb_bfm_apb_master_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  bfm_apb_master_arbiter_if #(.NUM_MASTERS(2)) bus ();

  bfm_apb_master_arbiter #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .PCLK_PM    (clk),
    .PRESETN_PM (rstn),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rq;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned wait_n;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_slverr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_rq(input int unsigned rq, input logic on, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.PSEL_RQ[rq]             = on;
    bus.PENABLE_RQ[rq]          = on;
    bus.PWRITE_RQ[rq]           = wr;
    bus.PADDR_RQ[32*rq +: 32]   = addr;
    bus.PWDATA_RQ[32*rq +: 32]  = wdata;
  endtask

  // Starts at a falling edge with the arbiter in IDLE; ends the same way.
  task automatic do_xfer(input vec_t v);
    bus.PRDATA_PM  = ~v.rdata;
    bus.PSLVERR_PM = ~v.err;
    drive_rq(v.rq, 1'b1, v.wr, v.addr, v.wdata);
    @(negedge clk);
    check("setup_gnt", bus.GNT_RQ, v.exp_gnt);
    check("setup_penable", bus.PENABLE_PM, 0);
    check("setup_paddr", bus.PADDR_PM, v.addr);
    check("setup_pwrite", bus.PWRITE_PM, v.wr);
    if (v.wr) check("setup_pwdata", bus.PWDATA_PM, v.wdata);
    for (int unsigned k = 0; k <= v.wait_n; k++) begin
      @(negedge clk);
      check("access_penable", bus.PENABLE_PM, 1);
      check("access_ready_rq", bus.PREADY_RQ, 0);
      if (k == v.wait_n) begin
        bus.PREADY_PM  = 1'b1;
        bus.PRDATA_PM  = v.rdata;
        bus.PSLVERR_PM = v.err;
      end
    end
    @(negedge clk);
    bus.PREADY_PM  = 1'b0;
    bus.PRDATA_PM  = ~v.rdata;
    bus.PSLVERR_PM = ~v.err;
    check("resp_penable", bus.PENABLE_PM, 0);
    check("resp_pready_rq", bus.PREADY_RQ, v.exp_ready);
    check("resp_pslverr_rq", bus.PSLVERR_RQ, v.exp_slverr);
    check("resp_prdata_rq", bus.PRDATA_RQ, v.rdata);
    drive_rq(v.rq, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("idle_gnt", bus.GNT_RQ, 0);
    check("idle_pready_rq", bus.PREADY_RQ, 0);
    check("idle_penable", bus.PENABLE_PM, 0);
    bus.PSLVERR_PM = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  exp_order[4];
    logic [1:0]  prev_gnt;
    logic        prev_en;
    logic        seen_en;
    int unsigned ng, low_run;
    vec_t        rv;

    vecs[0] = '{0, 1'b1, 32'h0300_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 4, 2'b01, 2'b01, 2'b00};
    vecs[1] = '{1, 1'b0, 32'h0500_0000, 32'h0000_0000, 32'h1234_5678, 1'b1, 0, 2'b10, 2'b10, 2'b10};
    vecs[2] = '{0, 1'b0, 32'h0300_0040, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0, 2, 2'b01, 2'b01, 2'b00};
    vecs[3] = '{1, 1'b1, 32'h0500_0100, 32'h0000_FFFF, 32'hCAFE_0001, 1'b0, 6, 2'b10, 2'b10, 2'b00};

    bus.PSEL_RQ = '0; bus.PENABLE_RQ = '0; bus.PWRITE_RQ = '0;
    bus.PADDR_RQ = '0; bus.PWDATA_RQ = '0;
    bus.PRDATA_PM = '0; bus.PREADY_PM = 1'b0; bus.PSLVERR_PM = 1'b0;

    #1;
    check("rst_paddr", bus.PADDR_PM, 0);
    check("rst_penable", bus.PENABLE_PM, 0);
    check("rst_gnt", bus.GNT_RQ, 0);
    check("rst_timeout", bus.TIMEOUT, 0);
    check("rst_prdata_rq", bus.PRDATA_RQ, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_xfer(vecs[i]);
      check("no_timeout", bus.TIMEOUT, 0);
    end

    // Contention: both requesters hold PSEL/PENABLE, zero-wait slave.
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    drive_rq(0, 1'b1, 1'b1, 32'h0300_0100, 32'h0000_0A0A);
    drive_rq(1, 1'b1, 1'b0, 32'h0500_0200, 32'h0000_0B0B);
    prev_gnt = 2'b00; prev_en = 1'b0; seen_en = 1'b0; ng = 0; low_run = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.PREADY_PM = bus.PENABLE_PM;
      if (bus.GNT_RQ != 2'b00 && prev_gnt == 2'b00) begin
        if (ng < 4) check("grant_order", bus.GNT_RQ, exp_order[ng]);
        ng++;
      end
      if (bus.PENABLE_PM && !prev_en) begin
        if (seen_en) check("penable_gap_ge2", (low_run >= 2), 1);
        seen_en = 1'b1;
      end
      low_run  = bus.PENABLE_PM ? 0 : low_run + 1;
      prev_gnt = bus.GNT_RQ;
      prev_en  = bus.PENABLE_PM;
    end
    check("grant_count_ge4", (ng >= 4), 1);
    drive_rq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_rq(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.PREADY_PM = bus.PENABLE_PM;
    end
    bus.PREADY_PM = 1'b0;
    check("drain_gnt", bus.GNT_RQ, 0);

    // Timeout: slave stalls until cycle 20.
    drive_rq(0, 1'b1, 1'b0, 32'h0700_0000, 32'h0);
    @(negedge clk);
    check("tmo_setup_gnt", bus.GNT_RQ, 2'b01);
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      check("tmo_penable", bus.PENABLE_PM, 1);
      if (j == 8) check("tmo_before", bus.TIMEOUT, 0);
      if (j == 9) check("tmo_after", bus.TIMEOUT, 1);
      if (j == 19) begin
        bus.PREADY_PM = 1'b1;
        bus.PRDATA_PM = 32'h0BAD_F00D;
      end
    end
    @(negedge clk);
    bus.PREADY_PM = 1'b0;
    bus.PRDATA_PM = 32'h0;
    check("tmo_pready_rq", bus.PREADY_RQ, 2'b01);
    check("tmo_prdata_rq", bus.PRDATA_RQ, 32'h0BAD_F00D);
    drive_rq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("tmo_sticky", bus.TIMEOUT, 1);
    check("tmo_idle_gnt", bus.GNT_RQ, 0);

    // Withdraw: RQ0 drops PSEL during ACCESS while RQ1 waits.
    drive_rq(0, 1'b1, 1'b1, 32'h0300_0020, 32'h0000_0011);
    @(negedge clk);
    check("wd_gnt0", bus.GNT_RQ, 2'b01);
    drive_rq(1, 1'b1, 1'b0, 32'h0500_0020, 32'h0);
    @(negedge clk);
    check("wd_access", bus.PENABLE_PM, 1);
    drive_rq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.PREADY_PM = 1'b1;
    bus.PRDATA_PM = 32'h5555_AAAA;
    @(negedge clk);
    bus.PREADY_PM = 1'b0;
    check("wd_no_ready", bus.PREADY_RQ, 0);
    check("wd_resp_penable", bus.PENABLE_PM, 0);
    @(negedge clk);
    check("wd_idle_gnt", bus.GNT_RQ, 0);
    @(negedge clk);
    check("wd_gnt1", bus.GNT_RQ, 2'b10);
    check("wd_paddr1", bus.PADDR_PM, 32'h0500_0020);
    check("wd_pwrite1", bus.PWRITE_PM, 0);
    @(negedge clk);
    bus.PREADY_PM = 1'b1;
    bus.PRDATA_PM = 32'h7777_0001;
    @(negedge clk);
    bus.PREADY_PM = 1'b0;
    check("wd_ready1", bus.PREADY_RQ, 2'b10);
    check("wd_prdata1", bus.PRDATA_RQ, 32'h7777_0001);
    drive_rq(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Reset pulse in the middle of ACCESS.
    drive_rq(0, 1'b1, 1'b1, 32'h0300_0030, 32'hABCD_0123);
    @(negedge clk);
    @(negedge clk);
    check("rm_access", bus.PENABLE_PM, 1);
    #2 rstn = 1'b0;
    #1;
    check("rm_penable", bus.PENABLE_PM, 0);
    check("rm_gnt", bus.GNT_RQ, 0);
    check("rm_paddr", bus.PADDR_PM, 0);
    check("rm_pwdata", bus.PWDATA_PM, 0);
    check("rm_pwrite", bus.PWRITE_PM, 0);
    check("rm_timeout", bus.TIMEOUT, 0);
    check("rm_prdata_rq", bus.PRDATA_RQ, 0);
    drive_rq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    rv = '{0, 1'b1, 32'h0300_0030, 32'hABCD_0123, 32'h0F0F_0F0F, 1'b0, 1, 2'b01, 2'b01, 2'b00};
    do_xfer(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
